cart_bus: RTL and testbench
===========================

# cart_bus

Responder for the cartridge access strobes issued by the SPI cartridge bridge. It converts single-cycle `cart_rd` / `cart_wr` pulses into a timed Game Boy cartridge bus cycle on the physical pins:
- drives address, `/CS`, `/RD`, `/WR` and the tri-state data bus;
- returns read data on `cart_dout`;
- reports `cart_busy` while a cycle is in flight.

It sits between the bridge and the FPGA's cartridge connector pins.

## Interface
Parameters:
- `SETUP_CYC`, 2: clk cycles of address/CS setup before the strobe; legal 1..255.
- `STROBE_CYC`, 6: clk cycles `/RD` or `/WR` is held low; legal 1..255.
- `HOLD_CYC`, 2: clk cycles of address/data hold after the strobe; legal 1..255.

Ports:
- `clk` in 1: single clock; all logic on its rising edge.
- `rst` in 1: asynchronous, active-high reset.
- `cart_a` in 16: request address, sampled only on the strobe cycle.
- `cart_din` in 8: write data, sampled only on the strobe cycle.
- `cart_rd` in 1: one-cycle read request pulse.
- `cart_wr` in 1: one-cycle write request pulse.
- `cart_dout` out 8: last read data.
- `cart_busy` out 1: a transaction is active or pending.
- `ovr` out 1: sticky request-dropped flag.
- `ovr_clr` in 1: clears `ovr`.
- `gb_a` out 16: cartridge address pins.
- `gb_d_out` out 8: data driven to the cartridge.
- `gb_d_oe` out 1: data bus output enable.
- `gb_d_in` in 8: data bus pins as read back.
- `gb_rd_n` out 1: cartridge `/RD`, active low.
- `gb_wr_n` out 1: cartridge `/WR`, active low.
- `gb_cs_n` out 1: cartridge `/CS`; low only when the latched address is in 0xA000–0xBFFF, and only during SETUP/STROBE/HOLD.

## Operation
- The initiator changes `cart_a` the cycle after a strobe. Address, data and direction are therefore latched on the strobe cycle itself.
- If `cart_rd` and `cart_wr` are high in the same cycle, the request is a write; the read is discarded.
- FSM states: IDLE, SETUP, STROBE, HOLD. One 8-bit down-counter is loaded on each state entry.
- IDLE → SETUP on an accepted request.
- SETUP → STROBE after `SETUP_CYC` cycles.
- STROBE → HOLD after `STROBE_CYC` cycles.
- HOLD → SETUP if a request is pending; otherwise HOLD → IDLE, after `HOLD_CYC` cycles.
- `gb_a` is driven from the latched address in all states. It keeps the last value in IDLE.
- `gb_rd_n` is low only in STROBE of a read. `gb_wr_n` is low only in STROBE of a write.
- `gb_d_oe` is high in SETUP, STROBE and HOLD of a write. `gb_d_out` holds the latched data.
- Reads capture `gb_d_in` into `cart_dout` on the last STROBE cycle. `cart_dout` is unchanged by writes and holds until the next read completes.
- A request arriving while not IDLE goes to the pending slot (see Configuration). If it cannot be held, it is dropped and `ovr` is set.
- `ovr_clr` clears `ovr`. If `ovr_clr` coincides with a new drop, `ovr` ends up set.

## Timing
- Strobe is sampled at cycle 0. The FSM is in SETUP from cycle 1, and `cart_busy` (registered) rises at cycle 1.
- `gb_rd_n` / `gb_wr_n` are low for cycles 1+SETUP_CYC .. SETUP_CYC+STROBE_CYC.
- `cart_dout` is valid from cycle SETUP_CYC+STROBE_CYC+1.
- A transaction occupies SETUP_CYC+STROBE_CYC+HOLD_CYC cycles. `cart_busy` falls the cycle after the last HOLD cycle unless a request is pending.
- Back-to-back (pending) transactions have no IDLE gap: HOLD → SETUP directly.
- A strobe in the same cycle the FSM leaves HOLD for IDLE is accepted as a new IDLE request; it is neither pending nor dropped.
- Reset values (asynchronous, immediate, including mid-transaction):
  - `gb_rd_n` = `gb_wr_n` = `gb_cs_n` = 1;
  - `gb_d_oe` = 0, `gb_a` = 0, `gb_d_out` = 0, `cart_dout` = 0;
  - `cart_busy` = 0, `ovr` = 0;
  - pending slot cleared, FSM in IDLE.

## Configuration
- `CART_BUS_PENDING_EN` defined: a one-entry pending slot holds address, data and direction.
  - A request while busy with the slot empty is stored.
  - A request while the slot is full is dropped and sets `ovr`.
- `CART_BUS_PENDING_EN` undefined: there is no slot. Every request while not IDLE is dropped and sets `ovr`.

## Test plan
- Reset mid-STROBE of a write → all strobes high, `gb_d_oe` = 0 and `cart_busy` = 0 in the same cycle; a read afterward completes normally.
- Read 0x4123 with `gb_d_in` = 0x5A and defaults → `gb_rd_n` low cycles 3..8, `gb_cs_n` stays 1, `cart_dout` = 0x5A at cycle 9, `cart_busy` high cycles 1..10.
- Write 0xA005 = 0xC3 → `gb_cs_n` low cycles 1..10, `gb_wr_n` low cycles 3..8, `gb_d_out` = 0xC3 with `gb_d_oe` high cycles 1..10, `cart_dout` unchanged.
- `cart_rd` and `cart_wr` together at 0x2000, `cart_din` = 0x01 → a write occurs; `gb_rd_n` never goes low.
- With `CART_BUS_PENDING_EN`: three reads at cycles 0, 2, 4 → the second runs from cycle 11 with no IDLE gap, the third is dropped, `ovr` = 1; `ovr_clr` pulse → `ovr` = 0.
- Without `CART_BUS_PENDING_EN`: a second read at cycle 2 → dropped, `ovr` = 1, `cart_busy` falls after cycle 10.

Source files
------------

// File: rtl/cart_bus.sv
`default_nettype none
// ============================================================================
// Module      : cart_bus
// Description : Game Boy cartridge bus responder. Turns single-cycle read /
//               write request pulses into a timed SETUP / STROBE / HOLD bus
//               cycle on the cartridge pins, returns read data and flags
//               requests that had to be dropped.
//               Optional macro CART_BUS_PENDING_EN adds a one-entry pending
//               slot so a request arriving mid-cycle runs back-to-back.
// Revision    : 1.0 - initial release
// ============================================================================
module cart_bus #(
    parameter int SETUP_CYC  = 2,
    parameter int STROBE_CYC = 6,
    parameter int HOLD_CYC   = 2
) (
    input  logic        clk,
    input  logic        rst,
    input  logic [15:0] cart_a,
    input  logic [7:0]  cart_din,
    input  logic        cart_rd,
    input  logic        cart_wr,
    output logic [7:0]  cart_dout,
    output logic        cart_busy,
    output logic        ovr,
    input  logic        ovr_clr,
    output logic [15:0] gb_a,
    output logic [7:0]  gb_d_out,
    output logic        gb_d_oe,
    input  logic [7:0]  gb_d_in,
    output logic        gb_rd_n,
    output logic        gb_wr_n,
    output logic        gb_cs_n
);

    localparam logic [1:0] c_ST_IDLE   = 2'd0;
    localparam logic [1:0] c_ST_SETUP  = 2'd1;
    localparam logic [1:0] c_ST_STROBE = 2'd2;
    localparam logic [1:0] c_ST_HOLD   = 2'd3;

    // Counter reload values: the counter runs N-1 .. 0 in an N-cycle state.
    localparam logic [7:0] c_SETUP_LD  = 8'(SETUP_CYC - 1);
    localparam logic [7:0] c_STROBE_LD = 8'(STROBE_CYC - 1);
    localparam logic [7:0] c_HOLD_LD   = 8'(HOLD_CYC - 1);

    logic [1:0]  r_state;
    logic [1:0]  w_state_nxt;
    logic [7:0]  r_cnt;
    logic [7:0]  w_cnt_ld;
    logic        w_cnt_load;
    logic        w_cnt_done;
    logic        w_take_new;
    logic        w_take_pend;
    logic        r_busy;

    logic [15:0] r_addr;
    logic [7:0]  r_data;
    logic        r_is_wr;
    logic [7:0]  r_dout;
    logic        r_ovr;

    logic        w_req;
    logic        w_busy_req;
    logic        w_drop;
    logic        w_pend_vld;
    logic [15:0] w_pend_a;
    logic [7:0]  w_pend_d;
    logic        w_pend_wr;

    assign w_req      = cart_rd | cart_wr;
    assign w_cnt_done = (r_cnt == 8'd0);
    // Any request not taken straight into the active cycle must be parked or dropped.
    assign w_busy_req = w_req & ~w_take_new;

`ifdef CART_BUS_PENDING_EN
    logic        r_pend_vld;
    logic [15:0] r_pend_a;
    logic [7:0]  r_pend_d;
    logic        r_pend_wr;

    // Pending slot: filled by a mid-cycle request, emptied when HOLD chains into SETUP.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_pend_vld <= 1'b0;
            r_pend_a   <= 16'd0;
            r_pend_d   <= 8'd0;
            r_pend_wr  <= 1'b0;
        end else if (w_take_pend) begin
            r_pend_vld <= 1'b0;
        end else if (w_busy_req && !r_pend_vld) begin
            r_pend_vld <= 1'b1;
            r_pend_a   <= cart_a;
            r_pend_d   <= cart_din;
            r_pend_wr  <= cart_wr;
        end
    end

    assign w_pend_vld = r_pend_vld;
    assign w_pend_a   = r_pend_a;
    assign w_pend_d   = r_pend_d;
    assign w_pend_wr  = r_pend_wr;
    // A full slot cannot accept anything, even in the cycle it is being drained.
    assign w_drop     = w_busy_req & r_pend_vld;
`else
    assign w_pend_vld = 1'b0;
    assign w_pend_a   = 16'd0;
    assign w_pend_d   = 8'd0;
    assign w_pend_wr  = 1'b0;
    assign w_drop     = w_busy_req;
`endif

    // State register, per-state down-counter and registered busy flag.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_state <= c_ST_IDLE;
            r_cnt   <= 8'd0;
            r_busy  <= 1'b0;
        end else begin
            r_state <= w_state_nxt;
            r_busy  <= (w_state_nxt != c_ST_IDLE);
            if (w_cnt_load) begin
                r_cnt <= w_cnt_ld;
            end else if (!w_cnt_done) begin
                r_cnt <= r_cnt - 8'd1;
            end
        end
    end

    // Next-state logic; also decides where the next cycle's address/data come from.
    always_comb begin
        w_state_nxt = r_state;
        w_cnt_load  = 1'b0;
        w_cnt_ld    = 8'd0;
        w_take_new  = 1'b0;
        w_take_pend = 1'b0;
        case (r_state)
            c_ST_IDLE: begin
                if (w_req) begin
                    w_state_nxt = c_ST_SETUP;
                    w_cnt_load  = 1'b1;
                    w_cnt_ld    = c_SETUP_LD;
                    w_take_new  = 1'b1;
                end
            end
            c_ST_SETUP: begin
                if (w_cnt_done) begin
                    w_state_nxt = c_ST_STROBE;
                    w_cnt_load  = 1'b1;
                    w_cnt_ld    = c_STROBE_LD;
                end
            end
            c_ST_STROBE: begin
                if (w_cnt_done) begin
                    w_state_nxt = c_ST_HOLD;
                    w_cnt_load  = 1'b1;
                    w_cnt_ld    = c_HOLD_LD;
                end
            end
            default: begin
                if (w_cnt_done) begin
                    if (w_pend_vld) begin
                        w_state_nxt = c_ST_SETUP;
                        w_cnt_load  = 1'b1;
                        w_cnt_ld    = c_SETUP_LD;
                        w_take_pend = 1'b1;
                    end else if (w_req) begin
                        // Strobe coinciding with the return to IDLE is a fresh request.
                        w_state_nxt = c_ST_SETUP;
                        w_cnt_load  = 1'b1;
                        w_cnt_ld    = c_SETUP_LD;
                        w_take_new  = 1'b1;
                    end else begin
                        w_state_nxt = c_ST_IDLE;
                    end
                end
            end
        endcase
    end

    // Pin outputs decoded from the current state and the latched request.
    always_comb begin
        gb_a     = r_addr;
        gb_d_out = r_data;
        gb_rd_n  = 1'b1;
        gb_wr_n  = 1'b1;
        gb_cs_n  = 1'b1;
        gb_d_oe  = 1'b0;
        if (r_state == c_ST_STROBE) begin
            gb_rd_n = r_is_wr;
            gb_wr_n = ~r_is_wr;
        end
        if (r_state != c_ST_IDLE) begin
            gb_cs_n = (r_addr[15:13] != 3'b101);
            gb_d_oe = r_is_wr;
        end
    end

    // Request latch, read-data capture on the last STROBE cycle, sticky overrun flag.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_addr  <= 16'd0;
            r_data  <= 8'd0;
            r_is_wr <= 1'b0;
            r_dout  <= 8'd0;
            r_ovr   <= 1'b0;
        end else begin
            if (w_take_new) begin
                r_addr  <= cart_a;
                r_data  <= cart_din;
                r_is_wr <= cart_wr;
            end else if (w_take_pend) begin
                r_addr  <= w_pend_a;
                r_data  <= w_pend_d;
                r_is_wr <= w_pend_wr;
            end
            if ((r_state == c_ST_STROBE) && w_cnt_done && !r_is_wr) begin
                r_dout <= gb_d_in;
            end
            // A new drop wins over a simultaneous clear.
            r_ovr <= (r_ovr & ~ovr_clr) | w_drop;
        end
    end

    assign cart_dout = r_dout;
    assign cart_busy = r_busy;
    assign ovr       = r_ovr;

endmodule
`default_nettype wire

// File: tb/tb_cart_bus.sv
`default_nettype none
// ============================================================================
// Module      : tb_cart_bus
// Description : Self-checking bench for cart_bus. A cartridge model answers
//               reads with a function of the address; expected transactions
//               are queued at issue time and checked when the bus strobe ends.
// Revision    : 1.0 - initial release
// ============================================================================
module tb_cart_bus;

    localparam int SETUP  = 2;
    localparam int STROBE = 6;
    localparam int HOLD   = 2;
    localparam int TXN    = SETUP + STROBE + HOLD;

    logic        clk = 1'b0;
    logic        rst = 1'b1;
    logic [15:0] cart_a = 16'd0;
    logic [7:0]  cart_din = 8'd0;
    logic        cart_rd = 1'b0;
    logic        cart_wr = 1'b0;
    logic [7:0]  cart_dout;
    logic        cart_busy;
    logic        ovr;
    logic        ovr_clr = 1'b0;
    logic [15:0] gb_a;
    logic [7:0]  gb_d_out;
    logic        gb_d_oe;
    logic [7:0]  gb_d_in;
    logic        gb_rd_n;
    logic        gb_wr_n;
    logic        gb_cs_n;

    int n_checks = 0;
    int n_errors = 0;
    int cyc = 0;
    bit mon_en = 1'b0;

    // Scoreboard entries: {is_wr, addr[15:0], data[7:0]}
    logic [24:0] sb_q[$];

    cart_bus #(
        .SETUP_CYC (SETUP),
        .STROBE_CYC(STROBE),
        .HOLD_CYC  (HOLD)
    ) dut (
        .clk      (clk),
        .rst      (rst),
        .cart_a   (cart_a),
        .cart_din (cart_din),
        .cart_rd  (cart_rd),
        .cart_wr  (cart_wr),
        .cart_dout(cart_dout),
        .cart_busy(cart_busy),
        .ovr      (ovr),
        .ovr_clr  (ovr_clr),
        .gb_a     (gb_a),
        .gb_d_out (gb_d_out),
        .gb_d_oe  (gb_d_oe),
        .gb_d_in  (gb_d_in),
        .gb_rd_n  (gb_rd_n),
        .gb_wr_n  (gb_wr_n),
        .gb_cs_n  (gb_cs_n)
    );

    always #5 clk = ~clk;

    function automatic logic [7:0] cart_model(input logic [15:0] a);
        return a[7:0] ^ a[15:8] ^ 8'h38;
    endfunction

    function automatic logic cs_exp(input logic [15:0] a);
        return !((a >= 16'hA000) && (a <= 16'hBFFF));
    endfunction

    assign gb_d_in = cart_model(gb_a);

    task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        n_checks++;
        if (obs !== exp) begin
            n_errors++;
            $display("FAIL %s: got %0h expected %0h (t=%0t)", tag, obs, exp, $time);
        end
    endtask

    task automatic sb_push(input logic is_wr, input logic [15:0] a, input logic [7:0] d);
        sb_q.push_back({is_wr, a, d});
    endtask

    task automatic sb_pop(output logic [24:0] ent, output bit ok);
        if (sb_q.size() == 0) begin
            ok  = 1'b0;
            ent = '0;
            check("sb_underflow", 64'd1, 64'd0);
        end else begin
            ok  = 1'b1;
            ent = sb_q.pop_front();
        end
    endtask

    // End of a read strobe: data must match the model for the queued address.
    always @(posedge gb_rd_n) begin
        logic [24:0] ent;
        bit ok;
        if (mon_en && !rst) begin
            #1;
            sb_pop(ent, ok);
            if (ok) begin
                check("rd_kind", 64'(ent[24]), 64'd0);
                check("rd_data", 64'(cart_dout), 64'(cart_model(ent[23:8])));
            end
        end
    end

    // End of a write strobe: address, data, enable and chip select on the pins.
    always @(posedge gb_wr_n) begin
        logic [24:0] ent;
        bit ok;
        if (mon_en && !rst) begin
            #1;
            sb_pop(ent, ok);
            if (ok) begin
                check("wr_kind", 64'(ent[24]), 64'd1);
                check("wr_bus", 64'({gb_a, gb_d_out, gb_d_oe, gb_cs_n}),
                      64'({ent[23:8], ent[7:0], 1'b1, cs_exp(ent[23:8])}));
            end
        end
    end

    // Advance to the next falling edge; request inputs are single-cycle and
    // address/data are scrambled afterwards to prove they were latched.
    task automatic next_cycle();
        @(negedge clk);
        cart_rd  = 1'b0;
        cart_wr  = 1'b0;
        ovr_clr  = 1'b0;
        cart_a   = 16'($urandom);
        cart_din = 8'($urandom);
        cyc++;
    endtask

    task automatic issue(input logic rd, input logic wr, input logic [15:0] a, input logic [7:0] d);
        cart_rd  = rd;
        cart_wr  = wr;
        cart_a   = a;
        cart_din = d;
    endtask

    task automatic wait_idle();
        int n;
        n = 0;
        while (cart_busy && n < 200) begin
            next_cycle();
            n++;
        end
        check("idle_reached", 64'(cart_busy), 64'd0);
        next_cycle();
    endtask

    initial begin
        logic exp_busy;
        logic exp_rdn;
        logic exp_ovr;

        // ---------------- reset values ----------------
        rst = 1'b1;
        next_cycle();
        next_cycle();
        rst = 1'b0;
        next_cycle();
        mon_en = 1'b1;
        check("reset_pins", 64'({gb_rd_n, gb_wr_n, gb_cs_n, gb_d_oe, gb_a, gb_d_out}),
              64'({1'b1, 1'b1, 1'b1, 1'b0, 16'h0000, 8'h00}));
        check("reset_status", 64'({cart_dout, cart_busy, ovr}), 64'({8'h00, 1'b0, 1'b0}));

        // ---------------- read 0x4123 ----------------
        next_cycle();
        cyc = 0;
        issue(1'b1, 1'b0, 16'h4123, 8'h00);
        sb_push(1'b0, 16'h4123, 8'h00);
        for (int k = 1; k <= TXN + 1; k++) begin
            next_cycle();
            check("rd_rd_n", 64'(gb_rd_n), 64'(!(k >= SETUP + 1 && k <= SETUP + STROBE)));
            check("rd_cs_n", 64'(gb_cs_n), 64'd1);
            check("rd_busy", 64'(cart_busy), 64'(k <= TXN));
            check("rd_dout", 64'(cart_dout), (k >= SETUP + STROBE + 1) ? 64'h5A : 64'h00);
        end
        wait_idle();

        // ---------------- write 0xA005 = 0xC3 ----------------
        cyc = 0;
        issue(1'b0, 1'b1, 16'hA005, 8'hC3);
        sb_push(1'b1, 16'hA005, 8'hC3);
        for (int k = 1; k <= TXN + 1; k++) begin
            next_cycle();
            check("wr_cs_n", 64'(gb_cs_n), 64'(!(k <= TXN)));
            check("wr_wr_n", 64'(gb_wr_n), 64'(!(k >= SETUP + 1 && k <= SETUP + STROBE)));
            check("wr_rd_n", 64'(gb_rd_n), 64'd1);
            check("wr_oe", 64'(gb_d_oe), 64'(k <= TXN));
            if (k <= TXN) check("wr_dout_pin", 64'(gb_d_out), 64'hC3);
            check("wr_cart_dout", 64'(cart_dout), 64'h5A);
        end
        wait_idle();

        // ---------------- read and write together -> write ----------------
        cyc = 0;
        issue(1'b1, 1'b1, 16'h2000, 8'h01);
        sb_push(1'b1, 16'h2000, 8'h01);
        for (int k = 1; k <= TXN + 1; k++) begin
            next_cycle();
            check("both_rd_n", 64'(gb_rd_n), 64'd1);
        end
        wait_idle();
        check("both_cart_dout", 64'(cart_dout), 64'h5A);

        // ---------------- requests while busy ----------------
        check("ovr_pre", 64'(ovr), 64'd0);
        cyc = 0;
        issue(1'b1, 1'b0, 16'h1111, 8'h00);
        sb_push(1'b0, 16'h1111, 8'h00);
        for (int k = 1; k <= 2 * TXN + 2; k++) begin
            next_cycle();
`ifdef CART_BUS_PENDING_EN
            exp_busy = (k <= 2 * TXN);
            exp_rdn  = !((k >= SETUP + 1 && k <= SETUP + STROBE) ||
                         (k >= TXN + SETUP + 1 && k <= TXN + SETUP + STROBE));
            exp_ovr  = (k >= 5);
            if (k == TXN + 1) check("pend_gb_a", 64'(gb_a), 64'h2222);
`else
            exp_busy = (k <= TXN);
            exp_rdn  = !(k >= SETUP + 1 && k <= SETUP + STROBE);
            exp_ovr  = (k >= 3);
`endif
            check("ovl_busy", 64'(cart_busy), 64'(exp_busy));
            check("ovl_rd_n", 64'(gb_rd_n), 64'(exp_rdn));
            check("ovl_ovr", 64'(ovr), 64'(exp_ovr));
            if (k == 2) begin
                issue(1'b1, 1'b0, 16'h2222, 8'h00);
`ifdef CART_BUS_PENDING_EN
                sb_push(1'b0, 16'h2222, 8'h00);
`endif
            end
            if (k == 4) begin
                // Dropped in both builds; the coincident clear must lose.
                issue(1'b1, 1'b0, 16'h3333, 8'h00);
                ovr_clr = 1'b1;
            end
        end
        wait_idle();
        check("ovr_held", 64'(ovr), 64'd1);
        ovr_clr = 1'b1;
        next_cycle();
        check("ovr_cleared", 64'(ovr), 64'd0);

        // ---------------- strobe on the last HOLD cycle ----------------
        cyc = 0;
        issue(1'b1, 1'b0, 16'h0100, 8'h00);
        sb_push(1'b0, 16'h0100, 8'h00);
        for (int k = 1; k <= TXN + SETUP + 1; k++) begin
            next_cycle();
            if (k == TXN) begin
                issue(1'b1, 1'b0, 16'hA100, 8'h00);
                sb_push(1'b0, 16'hA100, 8'h00);
            end
            if (k == TXN + 1) begin
                check("hx_busy", 64'(cart_busy), 64'd1);
                check("hx_gb_a", 64'(gb_a), 64'hA100);
                check("hx_cs_n", 64'(gb_cs_n), 64'd0);
            end
            if (k == TXN + SETUP + 1) check("hx_rd_n", 64'(gb_rd_n), 64'd0);
            check("hx_ovr", 64'(ovr), 64'd0);
        end
        wait_idle();

        // ---------------- reset in the middle of a write strobe ----------------
        cyc = 0;
        issue(1'b0, 1'b1, 16'hB0F0, 8'h77);
        sb_push(1'b1, 16'hB0F0, 8'h77);
        for (int k = 1; k <= SETUP + 3; k++) begin
            next_cycle();
        end
        check("mid_wr_n", 64'(gb_wr_n), 64'd0);
        rst = 1'b1;
        #1;
        sb_q.delete();
        check("rst_strobes", 64'({gb_rd_n, gb_wr_n, gb_cs_n}), 64'({1'b1, 1'b1, 1'b1}));
        check("rst_oe_busy", 64'({gb_d_oe, cart_busy, ovr}), 64'({1'b0, 1'b0, 1'b0}));
        check("rst_vals", 64'({gb_a, gb_d_out, cart_dout}), 64'({16'h0000, 8'h00, 8'h00}));
        next_cycle();
        rst = 1'b0;
        next_cycle();
        cyc = 0;
        issue(1'b1, 1'b0, 16'h4123, 8'h00);
        sb_push(1'b0, 16'h4123, 8'h00);
        next_cycle();
        check("post_rst_busy", 64'(cart_busy), 64'd1);
        wait_idle();
        check("post_rst_dout", 64'(cart_dout), 64'h5A);

        repeat (3) next_cycle();
        check("sb_empty", 64'(sb_q.size()), 64'd0);

        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end

endmodule
`default_nettype wire
